// File: rtl/game_link_pkg.sv
// Shared definitions for the inter-board game-state link (transmitter and receiver).
package game_link_pkg;

  localparam logic [7:0]  SYNC_BYTE      = 8'hA5;
  localparam int unsigned FRAME_LEN      = 10;
  localparam int unsigned PAYLOAD_LEN    = FRAME_LEN - 2;
  localparam int unsigned ENDGAME_BIT    = 0;
  localparam int unsigned WHISTLE_BIT    = 1;
  localparam int unsigned LAST_TOUCH_BIT = 2;

  typedef enum logic [1:0] {HUNT, PAYLOAD, CHECK} frame_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_bit_state_t;

  // Element 0 holds B1, element 7 holds B8.
  typedef logic [PAYLOAD_LEN-1:0][7:0] payload_t;

  typedef struct packed {
    logic [11:0] posx;
    logic [11:0] posy;
    logic [11:0] ballx;
    logic [11:0] bally;
    logic [3:0]  score1;
    logic [3:0]  score2;
    logic        endgame;
    logic        last_touch;
  } game_fields_t;

  function automatic game_fields_t unpack_fields(input payload_t p);
    game_fields_t f;
    f.posx       = {p[0], p[1][7:4]};
    f.posy       = {p[1][3:0], p[2]};
    f.ballx      = {p[3], p[4][7:4]};
    f.bally      = {p[4][3:0], p[5]};
    f.score1     = p[6][7:4];
    f.score2     = p[6][3:0];
    f.endgame    = p[7][ENDGAME_BIT];
    f.last_touch = p[7][LAST_TOUCH_BIT];
    return f;
  endfunction

endpackage

// File: rtl/game_state_rx_if.sv
// Game-state bus from the link receiver (master) to the game/render logic (slave).
interface game_state_rx_if;
  logic [11:0] pl1_posx;
  logic [11:0] pl1_posy;
  logic [11:0] ball_xpos;
  logic [11:0] ball_ypos;
  logic [3:0]  score_pl1;
  logic [3:0]  score_pl2;
  logic        endgame;
  logic        last_touch;
  logic        whistle_play;
  logic        frame_valid;
  logic        link_up;
  logic [7:0]  frame_err_cnt;

  modport master (
    output pl1_posx, pl1_posy, ball_xpos, ball_ypos, score_pl1, score_pl2,
           endgame, last_touch, whistle_play, frame_valid, link_up, frame_err_cnt
  );
  modport slave (
    input  pl1_posx, pl1_posy, ball_xpos, ball_ypos, score_pl1, score_pl2,
           endgame, last_touch, whistle_play, frame_valid, link_up, frame_err_cnt
  );
endinterface

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver: 2-FF synchroniser, mid-bit sampling, one-cycle valid / framing-error pulses.
module uart_byte_rx
  import game_link_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 564
) (
  input  logic       clk65MHz,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       byte_ferr
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);

  rx_bit_state_t    state_q, state_d;
  logic             sync1_q, sync2_q, prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             valid_q, valid_d, ferr_q, ferr_d;

  // Synchroniser resets to idle-high so a reset release never looks like a start edge.
  always_ff @(posedge clk65MHz) begin
    if (rst) begin
      state_q <= RX_IDLE;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (prev_q && !sync2_q) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_END) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = sync2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == BIT_END) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = RX_STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      RX_STOP: begin
        if (cnt_q == BIT_END) begin
          state_d = RX_IDLE;
          valid_d = sync2_q;
          ferr_d  = !sync2_q;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    byte_data  = shift_q;
    byte_valid = valid_q;
    byte_ferr  = ferr_q;
  end

endmodule

// File: rtl/game_state_rx.sv
// Game-state link receiver: header hunt, 10-byte frame assembly, XOR check, atomic field update.
module game_state_rx
  import game_link_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 65_000_000,
  parameter int unsigned BAUD         = 115_200,
  parameter int unsigned BYTE_TIMEOUT = 20_000,
  parameter int unsigned LINK_TIMEOUT = 6_500_000
) (
  input  logic            clk65MHz,
  input  logic            rst,
  input  logic            rx,
  game_state_rx_if.master gs
);

  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int unsigned GAP_W        = $clog2(BYTE_TIMEOUT + 1);
  localparam int unsigned LINK_W       = $clog2(LINK_TIMEOUT + 1);

  logic [7:0] byte_data;
  logic       byte_valid, byte_ferr;

  uart_byte_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte_rx (
    .clk65MHz  (clk65MHz),
    .rst       (rst),
    .rx        (rx),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .byte_ferr (byte_ferr)
  );

  frame_state_t      state_q, state_d;
  logic [2:0]        wptr_q;
  logic [7:0]        xor_q;
  payload_t          pay_q;
  logic [GAP_W-1:0]  gap_q;
  logic [LINK_W-1:0] link_cnt_q;
  game_fields_t      fields_q;
  logic              whistle_q, fv_q, link_up_q;
  logic [7:0]        err_q;

  logic timeout, start_frame, store_byte, accept, reject;

  assign timeout = (gap_q == GAP_W'(BYTE_TIMEOUT));

  always_ff @(posedge clk65MHz) begin
    if (rst) state_q <= HUNT;
    else     state_q <= state_d;
  end

  // A byte event in the same cycle as the gap limit wins over the timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      HUNT:    if (byte_valid && byte_data == SYNC_BYTE) state_d = PAYLOAD;
      PAYLOAD: begin
        if (byte_valid) begin
          if (wptr_q == 3'(PAYLOAD_LEN - 1)) state_d = CHECK;
        end else if (byte_ferr || timeout) begin
          state_d = HUNT;
        end
      end
      CHECK:   if (byte_valid || byte_ferr || timeout) state_d = HUNT;
      default: state_d = HUNT;
    endcase
  end

  always_comb begin
    start_frame = 1'b0;
    store_byte  = 1'b0;
    accept      = 1'b0;
    reject      = 1'b0;
    case (state_q)
      HUNT:    start_frame = byte_valid && (byte_data == SYNC_BYTE);
      PAYLOAD: begin
        store_byte = byte_valid;
        reject     = byte_ferr || (timeout && !byte_valid);
      end
      CHECK: begin
        accept = byte_valid && (byte_data == xor_q);
        reject = (byte_valid && (byte_data != xor_q)) || byte_ferr || (timeout && !byte_valid);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk65MHz) begin
    if (rst) begin
      wptr_q     <= '0;
      xor_q      <= '0;
      pay_q      <= '0;
      gap_q      <= '0;
      link_cnt_q <= '0;
      fields_q   <= '0;
      whistle_q  <= 1'b0;
      fv_q       <= 1'b0;
      link_up_q  <= 1'b0;
      err_q      <= '0;
    end else begin
      fv_q      <= accept;
      whistle_q <= accept && pay_q[PAYLOAD_LEN-1][WHISTLE_BIT];

      if (start_frame) begin
        wptr_q <= '0;
        xor_q  <= '0;
      end else if (store_byte) begin
        pay_q[wptr_q] <= byte_data;
        xor_q         <= xor_q ^ byte_data;
        wptr_q        <= wptr_q + 3'd1;
      end

      if (state_q == HUNT || byte_valid || byte_ferr) gap_q <= '0;
      else if (!timeout)                              gap_q <= gap_q + 1'b1;

      if (accept) fields_q <= unpack_fields(pay_q);

      if (reject && err_q != 8'hFF) err_q <= err_q + 8'd1;

      if (accept) begin
        link_up_q  <= 1'b1;
        link_cnt_q <= '0;
      end else if (link_up_q) begin
        if (link_cnt_q == LINK_W'(LINK_TIMEOUT - 1)) begin
          link_up_q  <= 1'b0;
          link_cnt_q <= '0;
        end else begin
          link_cnt_q <= link_cnt_q + 1'b1;
        end
      end
    end
  end

  assign gs.pl1_posx      = fields_q.posx;
  assign gs.pl1_posy      = fields_q.posy;
  assign gs.ball_xpos     = fields_q.ballx;
  assign gs.ball_ypos     = fields_q.bally;
  assign gs.score_pl1     = fields_q.score1;
  assign gs.score_pl2     = fields_q.score2;
  assign gs.endgame       = fields_q.endgame;
  assign gs.last_touch    = fields_q.last_touch;
  assign gs.whistle_play  = whistle_q;
  assign gs.frame_valid   = fv_q;
  assign gs.link_up       = link_up_q;
  assign gs.frame_err_cnt = err_q;

endmodule

// File: tb/tb_game_state_rx.sv
// Directed bench for game_state_rx with a shortened bit time and timeouts.
module tb_game_state_rx;

  localparam int unsigned CLK_HZ       = 400_000;
  localparam int unsigned BAUD         = 100_000;
  localparam int          CPB          = 4;
  localparam int unsigned BYTE_TIMEOUT = 100;
  localparam int unsigned LINK_TIMEOUT = 1000;

  logic clk65MHz = 1'b0;
  logic rst      = 1'b1;
  logic rx       = 1'b1;

  game_state_rx_if gs ();

  game_state_rx #(
    .CLK_HZ      (CLK_HZ),
    .BAUD        (BAUD),
    .BYTE_TIMEOUT(BYTE_TIMEOUT),
    .LINK_TIMEOUT(LINK_TIMEOUT)
  ) dut (
    .clk65MHz(clk65MHz),
    .rst     (rst),
    .rx      (rx),
    .gs      (gs)
  );

  always #5 clk65MHz = ~clk65MHz;

  int checks = 0, failures = 0;
  int cyc = 0, fv_cnt = 0, ws_cnt = 0, last_fv_cyc = 0;

  always @(posedge clk65MHz) cyc <= cyc + 1;

  always @(negedge clk65MHz) begin
    if (gs.frame_valid) begin
      fv_cnt      <= fv_cnt + 1;
      last_fv_cyc <= cyc;
    end
    if (gs.whistle_play) ws_cnt <= ws_cnt + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk65MHz);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    idle(CPB);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop_ok);
    if (!stop_ok) send_bit(1'b1);
  endtask

  // pl holds B1 in its top byte; bytes 0..last are sent, byte ferr_at gets a zero stop bit.
  task automatic send_frame(input logic [63:0] pl, input logic [7:0] ck, input int ferr_at,
                            input int last, input int gap_after, input int gap_len);
    logic [7:0] b;
    for (int k = 0; k <= last; k++) begin
      if (k == 0)      b = 8'hA5;
      else if (k == 9) b = ck;
      else             b = pl[71 - 8*k -: 8];
      send_byte(b, k != ferr_at);
      if (k == gap_after) idle(gap_len);
    end
    idle(3 * CPB);
  endtask

  task automatic check_fields(input string t, input logic [11:0] px, input logic [11:0] py,
                              input logic [11:0] bx, input logic [11:0] by, input logic [3:0] s1,
                              input logic [3:0] s2, input logic eg, input logic lt);
    check_eq({t, ".posx"},  32'(gs.pl1_posx),   32'(px));
    check_eq({t, ".posy"},  32'(gs.pl1_posy),   32'(py));
    check_eq({t, ".ballx"}, 32'(gs.ball_xpos),  32'(bx));
    check_eq({t, ".bally"}, 32'(gs.ball_ypos),  32'(by));
    check_eq({t, ".s1"},    32'(gs.score_pl1),  32'(s1));
    check_eq({t, ".s2"},    32'(gs.score_pl2),  32'(s2));
    check_eq({t, ".eg"},    32'(gs.endgame),    32'(eg));
    check_eq({t, ".lt"},    32'(gs.last_touch), 32'(lt));
  endtask

  task automatic check_zero(input string t);
    check_fields(t, 12'h0, 12'h0, 12'h0, 12'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    check_eq({t, ".whistle"}, 32'(gs.whistle_play),  32'd0);
    check_eq({t, ".fv"},      32'(gs.frame_valid),   32'd0);
    check_eq({t, ".link"},    32'(gs.link_up),       32'd0);
    check_eq({t, ".err"},     32'(gs.frame_err_cnt), 32'd0);
  endtask

  localparam logic [63:0] P1 = 64'h12_34_56_78_9A_BC_73_06;  // XOR = 8'h5B
  localparam logic [63:0] P3 = 64'hA5_6C_DE_24_68_AC_95_01;  // XOR = 8'h63
  localparam logic [63:0] P4 = 64'h11_22_33_44_55_66_12_04;  // XOR = 8'h61

  initial begin
    logic [63:0] pl;
    int target;
    pl = P4;

    rst = 1'b1;
    idle(5);
    check_zero("reset");
    rst = 1'b0;
    idle(5);

    send_frame(P1, 8'h5B, -1, 9, -1, 0);
    check_fields("t1", 12'h123, 12'h456, 12'h789, 12'hABC, 4'h7, 4'h3, 1'b0, 1'b1);
    check_eq("t1.link", 32'(gs.link_up), 32'd1);
    check_eq("t1.fv_pulses", 32'(fv_cnt), 32'd1);
    check_eq("t1.whistle_pulses", 32'(ws_cnt), 32'd1);
    check_eq("t1.err", 32'(gs.frame_err_cnt), 32'd0);

    send_frame(P1, 8'h00, -1, 9, -1, 0);
    check_eq("t2.err", 32'(gs.frame_err_cnt), 32'd1);
    check_eq("t2.fv_pulses", 32'(fv_cnt), 32'd1);
    check_eq("t2.whistle_pulses", 32'(ws_cnt), 32'd1);
    check_eq("t2.posx", 32'(gs.pl1_posx), 32'h123);

    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h3C, 1'b1);
    send_frame(P3, 8'h63, -1, 9, -1, 0);
    check_fields("t3", 12'hA56, 12'hCDE, 12'h246, 12'h8AC, 4'h9, 4'h5, 1'b1, 1'b0);
    check_eq("t3.fv_pulses", 32'(fv_cnt), 32'd2);
    check_eq("t3.whistle_pulses", 32'(ws_cnt), 32'd1);
    check_eq("t3.err", 32'(gs.frame_err_cnt), 32'd1);

    send_byte(8'h5A, 1'b0);
    idle(2 * CPB);
    check_eq("hunt_ferr.err", 32'(gs.frame_err_cnt), 32'd1);

    send_frame(P1, 8'h5B, 4, 4, -1, 0);
    check_eq("t4.err", 32'(gs.frame_err_cnt), 32'd2);
    check_eq("t4.fv_pulses", 32'(fv_cnt), 32'd2);
    check_eq("t4.posx_held", 32'(gs.pl1_posx), 32'hA56);

    // Inter-byte gap kept below BYTE_TIMEOUT must not abort the frame.
    send_frame(P4, 8'h61, -1, 9, 3, 40);
    check_fields("t4b", 12'h112, 12'h233, 12'h445, 12'h566, 4'h1, 4'h2, 1'b0, 1'b1);
    check_eq("t4b.fv_pulses", 32'(fv_cnt), 32'd3);
    check_eq("t4b.err", 32'(gs.frame_err_cnt), 32'd2);

    send_frame(P4, 8'h61, -1, 3, -1, 0);
    idle(BYTE_TIMEOUT + 1);
    check_eq("t5.timeout_err", 32'(gs.frame_err_cnt), 32'd3);
    // Back in HUNT: the rest of the frame must be ignored.
    for (int k = 4; k <= 8; k++) send_byte(pl[71 - 8*k -: 8], 1'b1);
    send_byte(8'h61, 1'b1);
    idle(3 * CPB);
    check_eq("t5.tail_fv", 32'(fv_cnt), 32'd3);
    check_eq("t5.tail_err", 32'(gs.frame_err_cnt), 32'd3);

    target = last_fv_cyc + int'(LINK_TIMEOUT) - 5;
    while (cyc < target) @(negedge clk65MHz);
    check_eq("t5.link_before", 32'(gs.link_up), 32'd1);
    target = last_fv_cyc + int'(LINK_TIMEOUT) + 5;
    while (cyc < target) @(negedge clk65MHz);
    check_eq("t5.link_after", 32'(gs.link_up), 32'd0);
    check_eq("t5.posx_held", 32'(gs.pl1_posx), 32'h112);
    check_eq("t5.lt_held", 32'(gs.last_touch), 32'd1);

    send_frame(P4, 8'h61, -1, 5, -1, 0);
    rx = 1'b0;
    idle(CPB);
    send_bit(1'b1);
    send_bit(1'b0);
    rst = 1'b1;
    @(posedge clk65MHz);
    #1;
    check_zero("t6.rst");
    idle(1);
    rx = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(3 * CPB);

    send_frame(P1, 8'h5B, -1, 9, -1, 0);
    check_fields("t6.post", 12'h123, 12'h456, 12'h789, 12'hABC, 4'h7, 4'h3, 1'b0, 1'b1);
    check_eq("t6.post_err", 32'(gs.frame_err_cnt), 32'd0);
    check_eq("t6.post_fv", 32'(fv_cnt), 32'd4);

    for (int i = 1; i <= 300; i++) begin
      send_byte(8'hA5, 1'b1);
      send_byte(8'h00, 1'b0);
      if (i == 254) check_eq("t6.err254", 32'(gs.frame_err_cnt), 32'd254);
      if (i == 255) check_eq("t6.err255", 32'(gs.frame_err_cnt), 32'd255);
    end
    idle(2 * CPB);
    check_eq("t6.err_sat", 32'(gs.frame_err_cnt), 32'd255);
    check_eq("t6.sat_fv", 32'(fv_cnt), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
